// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and constants for the router packet source
package router_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W     = 2;
    localparam int LEN_W_DEF  = DATA_W_DEF - ADDR_W;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        HEADER  = 3'd2,
        PAYLOAD = 3'd3,
        PARITY  = 3'd4,
        ERR_CHK = 3'd5
    } state_t;

endpackage

// File: rtl/router_pkt_tx_if.sv
// rtl/router_pkt_tx_if.sv - request, payload and router-side signals of the packet source
// master: the packet source (router_pkt_tx); slave: whoever feeds requests/payload and plays the router.
interface router_pkt_tx_if
    import router_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic                       req_valid;
    logic                       req_ready;
    logic [ADDR_W-1:0]          req_addr;
    logic [DATA_W-ADDR_W-1:0]   req_len;
    logic                       pl_valid;
    logic                       pl_ready;
    logic [DATA_W-1:0]          pl_data;
    logic                       busy;
    logic                       err;
    logic [DATA_W-1:0]          data_out;
    logic                       pkt_valid;
    logic                       tx_done;
    logic                       bad_req;
    logic [7:0]                 err_cnt;

    modport master (
        input  req_valid, req_addr, req_len, pl_valid, pl_data, busy, err,
        output req_ready, pl_ready, data_out, pkt_valid, tx_done, bad_req, err_cnt
    );

    modport slave (
        output req_valid, req_addr, req_len, pl_valid, pl_data, busy, err,
        input  req_ready, pl_ready, data_out, pkt_valid, tx_done, bad_req, err_cnt
    );

endinterface

// File: rtl/router_tx_buf.sv
// rtl/router_tx_buf.sv - payload store: DEPTH x DATA_W, synchronous write, combinational read
// clk: clock; wr_en/wptr/wdata: write port; rptr/rdata: read port.
module router_tx_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 63,
    parameter int PTR_W  = 6
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wptr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  rptr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en && (wptr < PTR_W'(DEPTH))) begin
            mem[wptr] <= wdata;
        end
    end

    // The read pointer steps one past the last byte when the packet ends.
    assign rdata = (rptr < PTR_W'(DEPTH)) ? mem[rptr] : '0;

endmodule

// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - buffered packet source for the 1x3 router input port
// clk/rst: clock and synchronous active-low reset.
// bus (master): request (req_*), payload fill (pl_*), router side (data_out, pkt_valid, busy, err),
//               status (tx_done, bad_req, err_cnt).
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_LEN  = 63,
    parameter int ERR_WAIT = 2
) (
    input  logic            clk,
    input  logic            rst,
    router_pkt_tx_if.master bus
);
    localparam int LEN_W  = DATA_W - ADDR_W;
    localparam int PTR_W  = $clog2(MAX_LEN + 1);
    localparam int WAIT_W = (ERR_WAIT > 1) ? $clog2(ERR_WAIT) : 1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [PTR_W-1:0]    wptr_q, wptr_d;
    logic [PTR_W-1:0]    rptr_q, rptr_d;
    logic [DATA_W-1:0]   parity_q, parity_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                err_seen_q, err_seen_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                pkt_valid_q, pkt_valid_d;
    logic                tx_done_q, tx_done_d;
    logic                bad_req_q, bad_req_d;

    logic                buf_we;
    logic [DATA_W-1:0]   buf_rdata;
    logic                req_legal;

    assign req_legal = (bus.req_addr != ADDR_INVALID) && (bus.req_len != '0);

    router_tx_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_LEN),
        .PTR_W  (PTR_W)
    ) u_buf (
        .clk   (clk),
        .wr_en (buf_we),
        .wptr  (wptr_q),
        .wdata (bus.pl_data),
        .rptr  (rptr_d),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            parity_q    <= '0;
            wait_q      <= '0;
            err_seen_q  <= 1'b0;
            err_cnt_q   <= '0;
            data_out_q  <= '0;
            pkt_valid_q <= 1'b0;
            tx_done_q   <= 1'b0;
            bad_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            parity_q    <= parity_d;
            wait_q      <= wait_d;
            err_seen_q  <= err_seen_d;
            err_cnt_q   <= err_cnt_d;
            data_out_q  <= data_out_d;
            pkt_valid_q <= pkt_valid_d;
            tx_done_q   <= tx_done_d;
            bad_req_q   <= bad_req_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        parity_d   = parity_q;
        wait_d     = wait_q;
        err_seen_d = err_seen_q;
        err_cnt_d  = err_cnt_q;
        buf_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_legal) begin
                    addr_d   = bus.req_addr;
                    len_d    = bus.req_len;
                    wptr_d   = '0;
                    rptr_d   = '0;
                    parity_d = {bus.req_len, bus.req_addr};
                    state_d  = FILL;
                end
            end
            FILL: begin
                if (bus.pl_valid) begin
                    buf_we   = 1'b1;
                    wptr_d   = wptr_q + 1'b1;
                    parity_d = parity_q ^ bus.pl_data;
                    if (wptr_d == PTR_W'(len_q)) begin
                        state_d = HEADER;
                    end
                end
            end
            HEADER: begin
                if (!bus.busy) begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!bus.busy) begin
                    rptr_d = rptr_q + 1'b1;
                    if (rptr_d == PTR_W'(len_q)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (!bus.busy) begin
                    wait_d     = '0;
                    err_seen_d = 1'b0;
                    state_d    = ERR_CHK;
                end
            end
            ERR_CHK: begin
                // Any err in the window counts the packet once.
                err_seen_d = err_seen_q | bus.err;
                if (wait_q == WAIT_W'(ERR_WAIT - 1)) begin
                    state_d = IDLE;
                    if (err_seen_d && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up
    // with the state they describe.
    always_comb begin
        data_out_d  = '0;
        pkt_valid_d = 1'b0;
        tx_done_d   = 1'b0;
        bad_req_d   = (state_q == IDLE) && bus.req_valid && !req_legal;
        case (state_d)
            HEADER: begin
                data_out_d  = {len_d, addr_d};
                pkt_valid_d = 1'b1;
            end
            PAYLOAD: begin
                data_out_d  = buf_rdata;
                pkt_valid_d = 1'b1;
            end
            PARITY:  data_out_d = parity_d;
            ERR_CHK: tx_done_d  = (wait_d == WAIT_W'(ERR_WAIT - 1));
            default: data_out_d = '0;
        endcase
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.pl_ready  = (state_q == FILL);
    assign bus.data_out  = data_out_q;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.tx_done   = tx_done_q;
    assign bus.bad_req   = bad_req_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb/tb_router_pkt_tx.sv - self-checking bench for router_pkt_tx
module tb_router_pkt_tx;

    localparam int DW   = 8;
    localparam int MAXL = 63;
    localparam int EW   = 2;

    typedef struct {
        logic [1:0]      addr;
        logic [5:0]      len;
        logic [3:0][7:0] pl;
        int              busy_hdr;
        int              busy_par;
        logic [EW-1:0]   err_mask;
        logic            exp_bad;
        logic [7:0]      exp_hdr;
        logic [7:0]      exp_par;
        logic            exp_err_inc;
    } vec_t;

    logic clk;
    logic rst;

    router_pkt_tx_if #(.DATA_W(DW)) bus ();

    router_pkt_tx #(
        .DATA_W   (DW),
        .MAX_LEN  (MAXL),
        .ERR_WAIT (EW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_chk;
    int         n_err;
    int         model_err_cnt;
    logic [7:0] cur_pl[$];
    vec_t       vecs[6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] model_hdr(input logic [1:0] a, input logic [5:0] l);
        return {l, a};
    endfunction

    function automatic logic [7:0] model_par(input logic [7:0] hdr);
        logic [7:0] p;
        p = hdr;
        foreach (cur_pl[i]) p = p ^ cur_pl[i];
        return p;
    endfunction

    // Entered and left at 1 time unit after a rising edge.
    task automatic do_req(input logic [1:0] a, input logic [5:0] l, input logic exp_bad);
        bus.req_addr  = a;
        bus.req_len   = l;
        bus.req_valid = 1'b1;
        bus.pl_valid  = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("bad_req_pulse", 32'(bus.bad_req), 32'(exp_bad));
        chk("req_ready_after_req", 32'(bus.req_ready), 32'(exp_bad));
        chk("pl_ready_after_req", 32'(bus.pl_ready), 32'(!exp_bad));
        chk("pkt_valid_after_req", 32'(bus.pkt_valid), 32'd0);
        @(posedge clk); #1;
        if (exp_bad) begin
            @(negedge clk);
            chk("bad_req_clears", 32'(bus.bad_req), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_fill(output bit ok);
        int   k;
        int   guard;
        logic acc;
        k = 0;
        guard = 0;
        while (k < cur_pl.size() && guard < 1000) begin
            bus.pl_valid = ($urandom_range(0, 2) != 0);
            bus.pl_data  = cur_pl[k];
            @(negedge clk);
            acc = bus.pl_valid && bus.pl_ready;
            @(posedge clk); #1;
            if (acc) k++;
            guard++;
        end
        bus.pl_valid = 1'b0;
        ok = (k == cur_pl.size());
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL fill_timeout: accepted %0d bytes, expected %0d", k, cur_pl.size());
        end
    endtask

    // Reference: the wire carries header, payload bytes, parity in order; each item
    // stays on the wire until a cycle with busy low, then ERR_WAIT quiet cycles.
    task automatic do_wire(input logic [7:0] hdr, input logic [7:0] par, input bit rnd_busy,
                           input int busy_hdr, input int busy_par, input logic [EW-1:0] err_mask,
                           input logic err_inc);
        logic [7:0] items[$];
        int         idx;
        int         spent;
        int         cyc;
        logic       b;
        items.push_back(hdr);
        foreach (cur_pl[i]) items.push_back(cur_pl[i]);
        items.push_back(par);
        idx = 0;
        spent = 0;
        cyc = 0;
        while (idx < items.size() && cyc < 2000) begin
            if (rnd_busy) b = ($urandom_range(0, 3) == 0) && (spent < 4);
            else b = ((idx == 0) && (spent < busy_hdr)) ||
                     ((idx == items.size() - 1) && (spent < busy_par));
            bus.busy     = b;
            bus.pl_valid = 1'($urandom_range(0, 1));
            bus.pl_data  = 8'($urandom);
            bus.err      = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("wire_data", 32'(bus.data_out), 32'(items[idx]));
            chk("wire_pkt_valid", 32'(bus.pkt_valid), 32'(idx < items.size() - 1));
            chk("wire_tx_done_low", 32'(bus.tx_done), 32'd0);
            @(posedge clk); #1;
            if (!b) begin
                idx++;
                spent = 0;
            end else begin
                spent++;
            end
            cyc++;
        end
        n_chk++;
        if (idx < items.size()) begin
            n_err++;
            $display("FAIL wire_timeout: sent %0d items, expected %0d", idx, items.size());
        end
        for (int w = 0; w < EW; w++) begin
            bus.err  = err_mask[w];
            bus.busy = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("errchk_data", 32'(bus.data_out), 32'd0);
            chk("errchk_pkt_valid", 32'(bus.pkt_valid), 32'd0);
            chk("errchk_tx_done", 32'(bus.tx_done), 32'(w == EW - 1));
            @(posedge clk); #1;
        end
        bus.err      = 1'b0;
        bus.busy     = 1'b0;
        bus.pl_valid = 1'b0;
        if (err_inc && model_err_cnt < 255) model_err_cnt++;
        @(negedge clk);
        chk("err_cnt", 32'(bus.err_cnt), 32'(model_err_cnt));
        chk("tx_done_single", 32'(bus.tx_done), 32'd0);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        chk("bad_req_idle", 32'(bus.bad_req), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        n_err++;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        logic [1:0] a;
        logic [5:0] l;

        n_chk = 0;
        n_err = 0;
        model_err_cnt = 0;

        vecs[0] = '{addr: 2'd1, len: 6'd3, pl: {8'h00, 8'h33, 8'h22, 8'h11}, busy_hdr: 0, busy_par: 0,
                    err_mask: 2'b00, exp_bad: 1'b0, exp_hdr: 8'h0D, exp_par: 8'h0D, exp_err_inc: 1'b0};
        vecs[1] = '{addr: 2'd1, len: 6'd3, pl: {8'h00, 8'h33, 8'h22, 8'h11}, busy_hdr: 2, busy_par: 0,
                    err_mask: 2'b00, exp_bad: 1'b0, exp_hdr: 8'h0D, exp_par: 8'h0D, exp_err_inc: 1'b0};
        vecs[2] = '{addr: 2'd1, len: 6'd3, pl: {8'h00, 8'h33, 8'h22, 8'h11}, busy_hdr: 0, busy_par: 3,
                    err_mask: 2'b00, exp_bad: 1'b0, exp_hdr: 8'h0D, exp_par: 8'h0D, exp_err_inc: 1'b0};
        vecs[3] = '{addr: 2'd2, len: 6'd1, pl: {8'h00, 8'h00, 8'h00, 8'h5A}, busy_hdr: 0, busy_par: 0,
                    err_mask: 2'b10, exp_bad: 1'b0, exp_hdr: 8'h06, exp_par: 8'h5C, exp_err_inc: 1'b1};
        vecs[4] = '{addr: 2'd3, len: 6'd4, pl: '0, busy_hdr: 0, busy_par: 0,
                    err_mask: 2'b00, exp_bad: 1'b1, exp_hdr: 8'h00, exp_par: 8'h00, exp_err_inc: 1'b0};
        vecs[5] = '{addr: 2'd0, len: 6'd0, pl: '0, busy_hdr: 0, busy_par: 0,
                    err_mask: 2'b00, exp_bad: 1'b1, exp_hdr: 8'h00, exp_par: 8'h00, exp_err_inc: 1'b0};

        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.pl_valid  = 1'b0;
        bus.pl_data   = '0;
        bus.busy      = 1'b0;
        bus.err       = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        @(negedge clk);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_pl_ready", 32'(bus.pl_ready), 32'd0);
        chk("reset_pkt_valid", 32'(bus.pkt_valid), 32'd0);
        chk("reset_data_out", 32'(bus.data_out), 32'd0);
        chk("reset_tx_done", 32'(bus.tx_done), 32'd0);
        chk("reset_bad_req", 32'(bus.bad_req), 32'd0);
        chk("reset_err_cnt", 32'(bus.err_cnt), 32'd0);
        @(posedge clk); #1;

        for (int r = 0; r < 6; r++) begin
            cur_pl.delete();
            for (int i = 0; i < 4; i++) if (i < int'(vecs[r].len)) cur_pl.push_back(vecs[r].pl[i]);
            do_req(vecs[r].addr, vecs[r].len, vecs[r].exp_bad);
            if (!vecs[r].exp_bad) begin
                do_fill(ok);
                if (ok) do_wire(vecs[r].exp_hdr, vecs[r].exp_par, 1'b0, vecs[r].busy_hdr,
                                vecs[r].busy_par, vecs[r].err_mask, vecs[r].exp_err_inc);
            end
        end

        // Reset while the second payload byte is on the wire, with a request pending.
        cur_pl = '{8'h11, 8'h22, 8'h33};
        do_req(2'd1, 6'd3, 1'b0);
        do_fill(ok);
        bus.busy = 1'b0;
        @(negedge clk);
        chk("rst_seq_hdr", 32'(bus.data_out), 32'h0D);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_seq_byte0", 32'(bus.data_out), 32'h11);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_seq_byte1", 32'(bus.data_out), 32'h22);
        chk("rst_seq_pv", 32'(bus.pkt_valid), 32'd1);
        rst           = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 2'd2;
        bus.req_len   = 6'd5;
        @(posedge clk); #1;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        model_err_cnt = 0;
        @(negedge clk);
        chk("rst_mid_pkt_valid", 32'(bus.pkt_valid), 32'd0);
        chk("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_mid_pl_ready", 32'(bus.pl_ready), 32'd0);
        chk("rst_mid_data_out", 32'(bus.data_out), 32'd0);
        chk("rst_mid_err_cnt", 32'(bus.err_cnt), 32'd0);
        @(posedge clk); #1;
        cur_pl = '{8'hA5, 8'h3C};
        do_req(2'd0, 6'd2, 1'b0);
        do_fill(ok);
        if (ok) do_wire(model_hdr(2'd0, 6'd2), model_par(model_hdr(2'd0, 6'd2)), 1'b0, 0, 0, 2'b00, 1'b0);

        // Randomised packets, first one at maximum length.
        for (int p = 0; p < 40; p++) begin
            logic [EW-1:0] m;
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1) do_req(2'd3, 6'($urandom_range(0, 63)), 1'b1);
                else do_req(2'($urandom_range(0, 2)), 6'd0, 1'b1);
            end
            a = 2'($urandom_range(0, 2));
            l = (p == 0) ? 6'(MAXL) : 6'($urandom_range(1, MAXL));
            cur_pl.delete();
            for (int i = 0; i < int'(l); i++) cur_pl.push_back(8'($urandom));
            m = EW'($urandom_range(0, (1 << EW) - 1));
            do_req(a, l, 1'b0);
            do_fill(ok);
            if (ok) do_wire(model_hdr(a, l), model_par(model_hdr(a, l)), 1'b1, 0, 0, m, |m);
        end

        // Drive err on every packet until the counter must saturate.
        for (int p = 0; p < 258; p++) begin
            a = 2'($urandom_range(0, 2));
            cur_pl = '{8'($urandom)};
            do_req(a, 6'd1, 1'b0);
            do_fill(ok);
            if (ok) do_wire(model_hdr(a, 6'd1), model_par(model_hdr(a, 6'd1)), 1'b0, 0, 0, '1, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
